instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//  Run-time writer for the BIP2 instruction memory: takes a byte stream (e.g. from UART RX),
//  parses a word-count header, packs bytes MSB-first into instructions and drives the memory
//  write port at sequential addresses from 0. Holds the CPU while a load is in progress.
// PARAMETERS
//  INSTRUCTION_WIDTH  16  instruction word width in bits; must be a multiple of 8
//  ADDRESS_WIDTH      11  instruction memory address width; depth = 2**ADDRESS_WIDTH; must be <= 16
// PORTS
//  clock_in           in   1                  single clock; all state on rising edge
//  reset_in           in   1                  asynchronous, active-high reset
//  start_in           in   1                  start a load session (sampled in IDLE/DONE/ERROR)
//  byte_in            in   8                  stream byte
//  byte_valid_in      in   1                  byte_in is valid
//  byte_ready_out     out  1                  loader can accept; transfer = valid & ready at edge
//  write_enable_out   out  1                  one-cycle memory write strobe
//  write_address_out  out  ADDRESS_WIDTH      memory write address
//  write_data_out     out  INSTRUCTION_WIDTH  memory write data
//  cpu_hold_out       out  1                  high while loading; CPU must stall/stay in reset
//  done_out           out  1                  one-cycle pulse on successful completion
//  error_out          out  1                  high while in ERROR
// BEHAVIOUR
//  - Reset (async): state=IDLE; every output 0; word count, byte counter, address, data cleared.
//  - All outputs are registered/Moore (decoded from state and registers only).
//  - Stream format: COUNT[15:8], COUNT[7:0], then COUNT words of INSTRUCTION_WIDTH/8 bytes, MSB first.
//  - States:
//    IDLE     : ready=0, hold=0. start_in=1 -> COUNT_HI.
//    COUNT_HI : ready=1, hold=1. byte accepted -> COUNT[15:8]; -> COUNT_LO.
//    COUNT_LO : ready=1. byte accepted -> COUNT[7:0]; COUNT==0 or COUNT>2**ADDRESS_WIDTH -> ERROR,
//               else address=0 -> DATA.
//    DATA     : ready=1. byte shifted into data register (MSB first); on the last byte of a word -> WRITE.
//    WRITE    : ready=0 (one cycle), write_enable_out=1, address/data stable.
//               next: address==COUNT-1 -> DONE (or CHECK, see CONFIGURATION); else address+1, -> DATA.
//    DONE     : done_out=1, hold=0, one cycle -> IDLE; start_in=1 here -> COUNT_HI instead.
//    ERROR    : error_out=1, hold=1, ready=0; stays until start_in=1 (-> COUNT_HI) or reset.
//  - Latency: last byte of word accepted at edge k -> write_enable_out high in cycle k+1.
//  - start_in ignored in COUNT_HI/COUNT_LO/DATA/WRITE (no restart mid-load).
//  - Byte gaps (valid low) allowed anywhere; partial word/byte counter persists.
//  - Byte held valid during WRITE is not consumed; accepted in the following DATA cycle.
//  - Address never wraps: COUNT <= depth, so the last write is at COUNT-1 <= 2**ADDRESS_WIDTH-1.
//  - Reset mid-load: immediate return to IDLE; already-written words are not undone.
//  - Bytes arriving in IDLE/DONE/ERROR are not accepted (ready=0).
// CONFIGURATION
//  Macro LOADER_CHECKSUM_EN:
//  - Defined: extra state CHECK (ready=1, hold=1) after the last WRITE; consumes one checksum byte.
//    8-bit sum of all stream bytes (count, data, checksum) mod 256 == 0 -> DONE, else -> ERROR.
//    Words are already written on error; error_out tells the host to reload.
//  - Not defined: no CHECK state and no sum register; the last WRITE goes directly to DONE.
// TESTING
//  1. start; bytes 00 02 12 34 AB CD -> writes (0,0x1234),(1,0xABCD); done_out pulse the cycle after
//     the second write; cpu_hold_out high from the cycle after start until DONE.
//  2. start; bytes 00 00 -> error_out=1, no write_enable_out, byte_ready_out=0; start_in -> COUNT_HI.
//  3. start; bytes 08 01 (2049, depth 2048) -> ERROR; bytes 08 00 followed by 2048 words -> last
//     write at address 0x7FF, then DONE.
//  4. byte_valid_in held high continuously, data 00 01 AA 55 -> byte_ready_out=0 in the WRITE cycle;
//     no byte lost or duplicated; write (0,0xAA55).
//  5. reset_in pulsed after 1 data byte -> all outputs 0 asynchronously; new load 00 01 BE EF
//     -> write (0,0xBEEF).
//  6. LOADER_CHECKSUM_EN: 00 01 12 34 B9 -> done_out; 00 01 12 34 B8 -> write (0,0x1234),
//     then error_out=1.

Source files
------------

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module     : instruction_loader
// Description: Parses a count-prefixed byte stream and writes packed
//              instruction words to memory, holding the CPU while loading.
//              Optional trailing checksum byte with LOADER_CHECKSUM_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module instruction_loader #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = 11
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid_in,
    output logic                         byte_ready_out,
    output logic                         write_enable_out,
    output logic [ADDRESS_WIDTH-1:0]     write_address_out,
    output logic [INSTRUCTION_WIDTH-1:0] write_data_out,
    output logic                         cpu_hold_out,
    output logic                         done_out,
    output logic                         error_out
);

    localparam int              c_BYTES     = INSTRUCTION_WIDTH / 8;
    localparam int              c_BCW       = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BYTES - 1);
    localparam logic [16:0]     c_DEPTH     = 17'(1) << ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COUNT_HI = 3'd1,
        S_COUNT_LO = 3'd2,
        S_DATA     = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK    = 3'd7,
`endif
        S_ERROR    = 3'd6
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [15:0]                    r_count;
    logic [c_BCW-1:0]               r_byte_cnt;
    logic [ADDRESS_WIDTH-1:0]       r_addr;
    logic [INSTRUCTION_WIDTH-1:0]   r_data;
    logic                           r_ready, r_we, r_hold, r_done, r_error;
    logic                           w_xfer, w_count_bad, w_last_addr, w_last_byte;
    logic                           w_ready_n, w_hold_n;
    logic [15:0]                    w_count_new;

    assign w_xfer      = byte_valid_in & r_ready;
    assign w_count_new = {r_count[15:8], byte_in};
    assign w_count_bad = (w_count_new == 16'd0) || (17'(w_count_new) > c_DEPTH);
    // 17-bit compare so a full-depth count never aliases with address 0
    assign w_last_addr = (17'(r_addr) == (17'(r_count) - 17'd1));
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_next;
    assign w_sum_next = r_sum + byte_in;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start_in) w_next = S_COUNT_HI;
            S_COUNT_HI: if (w_xfer) w_next = S_COUNT_LO;
            S_COUNT_LO: if (w_xfer) w_next = w_count_bad ? S_ERROR : S_DATA;
            S_DATA:     if (w_xfer && w_last_byte) w_next = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
            S_WRITE:    w_next = w_last_addr ? S_CHECK : S_DATA;
            S_CHECK:    if (w_xfer) w_next = (w_sum_next == 8'd0) ? S_DONE : S_ERROR;
`else
            S_WRITE:    w_next = w_last_addr ? S_DONE : S_DATA;
`endif
            S_DONE:     w_next = start_in ? S_COUNT_HI : S_IDLE;
            S_ERROR:    if (start_in) w_next = S_COUNT_HI;
            default:    w_next = S_IDLE;
        endcase
        w_ready_n = (w_next == S_COUNT_HI) || (w_next == S_COUNT_LO) || (w_next == S_DATA);
        w_hold_n  = w_ready_n || (w_next == S_WRITE) || (w_next == S_ERROR);
`ifdef LOADER_CHECKSUM_EN
        if (w_next == S_CHECK) begin
            w_ready_n = 1'b1;
            w_hold_n  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_ready <= w_ready_n;
            r_hold  <= w_hold_n;
            r_we    <= (w_next == S_WRITE);
            r_done  <= (w_next == S_DONE);
            r_error <= (w_next == S_ERROR);
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_in) r_byte_cnt <= '0;
                end
                S_COUNT_HI: if (w_xfer) r_count[15:8] <= byte_in;
                S_COUNT_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= byte_in;
                        r_addr       <= '0;
                        r_byte_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_data     <= (r_data << 8) | INSTRUCTION_WIDTH'(byte_in);
                        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
                    end
                end
                S_WRITE: if (!w_last_addr) r_addr <= r_addr + 1'b1;
                default: ;
            endcase
`ifdef LOADER_CHECKSUM_EN
            // Ready is low in IDLE/DONE/ERROR, so a start never collides with an accepted byte
            if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR) && start_in)
                r_sum <= '0;
            else if (w_xfer)
                r_sum <= w_sum_next;
`endif
        end
    end

    assign byte_ready_out    = r_ready;
    assign write_enable_out  = r_we;
    assign write_address_out = r_addr;
    assign write_data_out    = r_data;
    assign cpu_hold_out      = r_hold;
    assign done_out          = r_done;
    assign error_out         = r_error;

endmodule
`default_nettype wire
